// File: rtl/multibyte_add_seq.sv
// Wide add/subtract sequencer: one 8-bit carry-lookahead slice is reused
// over BYTES cycles, least-significant byte first, with a registered carry.

module multibyte_add_seq_cla8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_c,
    output logic [7:0] o_s,
    output logic       o_c
);
    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [8:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin
        w_c    = '0;
        w_c[0] = i_c;
        for (int i = 0; i < 8; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
    end

    assign o_s = w_p ^ w_c[7:0];
    assign o_c = w_c[8];
endmodule

module multibyte_add_seq #(
    parameter  int BYTES = 4,
    parameter  int CNTW  = 4,
    localparam int W     = 8 * BYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op_sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CNTW-1:0] r_k;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_work;
    logic [W-1:0]    r_result;
    logic            r_sub;
    logic            r_carry;
    logic            r_cout;
    logic            r_ovf;
    logic            r_zero;

    logic [7:0]      w_bx;
    logic [7:0]      w_s;
    logic            w_co;
    logic            w_last;
    logic            w_take;
    logic            w_ovf;
    logic [W-1:0]    w_final;

    // Operands shift down one byte per step so the slice always sees byte 0.
    assign w_bx    = r_b[7:0] ^ {8{r_sub}};
    assign w_last  = (r_k == CNTW'(BYTES - 1));
    assign w_take  = start && (r_state != RUN);
    assign w_final = {w_s, r_work[W-1:8]};
    assign w_ovf   = (r_a[7] == w_bx[7]) && (w_s[7] != r_a[7]);

    multibyte_add_seq_cla8 u_slice (
        .i_a (r_a[7:0]),
        .i_b (w_bx),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_co)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = FIN;
            FIN:     w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_work   <= '0;
            r_sub    <= 1'b0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_take) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= op_sub;
            r_carry <= op_sub;
            r_work  <= '0;
            r_k     <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 8;
            r_b     <= r_b >> 8;
            r_work  <= w_final;
            r_carry <= w_co;
            r_k     <= r_k + CNTW'(1);
            if (w_last) begin
                r_result <= w_final;
                r_cout   <= w_co;
                r_ovf    <= w_ovf;
                r_zero   <= (w_final == '0);
            end
        end
    end

    assign busy   = (r_state == RUN);
    assign done   = (r_state == FIN);
    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;
    assign zero   = r_zero;
endmodule
